// File: rtl/cvxif_pkg.sv
// Shared types and constants for the CV-X-IF issuer: FSM states, completion status codes
// and the custom-3 opcode used by coprocessor instructions.
package cvxif_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_REGS,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    STATUS_OK      = 2'd0,
    STATUS_REJECT  = 2'd1,
    STATUS_TIMEOUT = 2'd2
  } status_t;

  localparam logic [6:0] CUSTOM3_OPCODE = 7'b1111011;

endpackage

// File: rtl/cvxif_timeout_ctr.sv
// Result-wait counter: cleared while the issuer is outside WAIT, counts stalled WAIT cycles
// and flags the terminal count TIMEOUT_CYCLES-1 (saturates there).
module cvxif_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !tc_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cvxif_issuer.sv
// Single-outstanding CV-X-IF issuer between core and coprocessor.
// Optional result-wait timeout is built only with `define CVXIF_ISSUER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a core request; captures instr/rs1/rs2
// ISSUE | offering the instruction to the coprocessor
// REGS  | offering requested operands
// WAIT  | waiting for the result (or skipping it when no writeback)
// RESP  | presenting completion status/data to the core
module cvxif_issuer
  import cvxif_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_instr,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [31:0] issue_req_instr,
  input  logic        issue_resp_accept,
  input  logic        issue_resp_writeback,
  input  logic [1:0]  issue_resp_register_read,
  output logic        register_valid,
  input  logic        register_ready,
  output logic [31:0] register_rs [0:1],
  output logic [1:0]  register_rs_valid,
  input  logic        result_valid,
  output logic        result_ready,
  input  logic [31:0] result_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_status,
  output logic [31:0] rsp_data
);

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("cvxif_issuer: TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic [1:0]  mask_q, mask_d;
  logic        wb_q, wb_d;
  status_t     status_q, status_d;
  logic [31:0] data_q, data_d;
  logic        tmo_hit;

`ifdef CVXIF_ISSUER_TIMEOUT_EN
  // Held clear outside WAIT, so every WAIT entry starts counting from zero.
  cvxif_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q != ST_WAIT),
    .inc_i ((state_q == ST_WAIT) && !result_valid),
    .tc_o  (tmo_hit)
  );
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d           = state_q;
    instr_d           = instr_q;
    rs1_d             = rs1_q;
    rs2_d             = rs2_q;
    mask_d            = mask_q;
    wb_d              = wb_q;
    status_d          = status_q;
    data_d            = data_q;
    req_ready         = 1'b0;
    issue_valid       = 1'b0;
    issue_req_instr   = '0;
    register_valid    = 1'b0;
    register_rs[0]    = '0;
    register_rs[1]    = '0;
    register_rs_valid = 2'b00;
    result_ready      = 1'b0;
    rsp_valid         = 1'b0;
    rsp_status        = 2'b00;
    rsp_data          = '0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          instr_d  = req_instr;
          rs1_d    = req_rs1;
          rs2_d    = req_rs2;
          mask_d   = 2'b00;
          wb_d     = 1'b0;
          status_d = STATUS_OK;
          data_d   = '0;
          state_d  = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        issue_valid     = 1'b1;
        issue_req_instr = instr_q;
        if (issue_ready) begin
          if (!issue_resp_accept) begin
            status_d = STATUS_REJECT;
            data_d   = '0;
            state_d  = ST_RESP;
          end else begin
            mask_d  = issue_resp_register_read;
            wb_d    = issue_resp_writeback;
            state_d = (issue_resp_register_read == 2'b00) ? ST_WAIT : ST_REGS;
          end
        end
      end

      ST_REGS: begin
        register_valid    = 1'b1;
        register_rs_valid = mask_q;
        register_rs[0]    = mask_q[0] ? rs1_q : '0;
        register_rs[1]    = mask_q[1] ? rs2_q : '0;
        if (register_ready) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        result_ready = wb_q;
        // A result arriving on the timeout cycle takes priority over the timeout.
        if (!wb_q) begin
          status_d = STATUS_OK;
          data_d   = '0;
          state_d  = ST_RESP;
        end else if (result_valid) begin
          status_d = STATUS_OK;
          data_d   = result_data;
          state_d  = ST_RESP;
        end else if (tmo_hit) begin
          status_d = STATUS_TIMEOUT;
          data_d   = '0;
          state_d  = ST_RESP;
        end
      end

      ST_RESP: begin
        rsp_valid  = 1'b1;
        rsp_status = status_q;
        rsp_data   = data_q;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      mask_q   <= 2'b00;
      wb_q     <= 1'b0;
      status_q <= STATUS_OK;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      mask_q   <= mask_d;
      wb_q     <= wb_d;
      status_q <= status_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: tb/tb_cvxif_issuer.sv
// Directed self-checking bench for cvxif_issuer; timeout checks apply when
// CVXIF_ISSUER_TIMEOUT_EN is defined, otherwise the indefinite wait is checked.
module tb_cvxif_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_instr, req_rs1, req_rs2;
  logic        issue_valid, issue_ready;
  logic [31:0] issue_req_instr;
  logic        issue_resp_accept, issue_resp_writeback;
  logic [1:0]  issue_resp_register_read;
  logic        register_valid, register_ready;
  logic [31:0] register_rs [0:1];
  logic [1:0]  register_rs_valid;
  logic        result_valid, result_ready;
  logic [31:0] result_data;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_data;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_cmp  = 0;
  logic saw_regv = 1'b0;

  always #5 clk = ~clk;

  cvxif_issuer #(.TIMEOUT_CYCLES(8)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .req_valid                (req_valid),
    .req_ready                (req_ready),
    .req_instr                (req_instr),
    .req_rs1                  (req_rs1),
    .req_rs2                  (req_rs2),
    .issue_valid              (issue_valid),
    .issue_ready              (issue_ready),
    .issue_req_instr          (issue_req_instr),
    .issue_resp_accept        (issue_resp_accept),
    .issue_resp_writeback     (issue_resp_writeback),
    .issue_resp_register_read (issue_resp_register_read),
    .register_valid           (register_valid),
    .register_ready           (register_ready),
    .register_rs              (register_rs),
    .register_rs_valid        (register_rs_valid),
    .result_valid             (result_valid),
    .result_ready             (result_ready),
    .result_data              (result_data),
    .rsp_valid                (rsp_valid),
    .rsp_ready                (rsp_ready),
    .rsp_status               (rsp_status),
    .rsp_data                 (rsp_data)
  );

  always @(posedge clk) begin
    if (!rst && rsp_valid && rsp_ready) n_cmp++;
    if (register_valid) saw_regv = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_inputs;
    req_valid = 0; req_instr = 0; req_rs1 = 0; req_rs2 = 0;
    issue_ready = 0; issue_resp_accept = 0; issue_resp_writeback = 0;
    issue_resp_register_read = 0; register_ready = 0;
    result_valid = 0; result_data = 0; rsp_ready = 0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic run_txn(input string tag, input logic [31:0] instr, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic acc, input logic wb,
                         input logic [1:0] mask, input logic [31:0] res, input int is_st,
                         input int rg_st, input int res_dly, input int rsp_st,
                         input logic [1:0] exp_st, input logic [31:0] exp_dat, output int lat);
    int c0, n0;
    chk({tag, ".idle_req_ready"}, req_ready, 1);
    n0 = n_cmp; saw_regv = 0; c0 = cyc;
    req_valid = 1; req_instr = instr; req_rs1 = rs1; req_rs2 = rs2;
    issue_ready = (is_st == 0); issue_resp_accept = acc;
    issue_resp_writeback = wb; issue_resp_register_read = mask;
    tick();
    req_valid = 0; req_instr = 32'hDEADBEEF; req_rs1 = ~rs1; req_rs2 = ~rs2;
    chk({tag, ".issue_valid"}, issue_valid, 1);
    chk({tag, ".issue_instr"}, issue_req_instr, instr);
    chk({tag, ".busy_req_ready"}, req_ready, 0);
    for (int i = 1; i <= is_st; i++) begin
      tick();
      chk({tag, ".issue_hold_valid"}, issue_valid, 1);
      chk({tag, ".issue_hold_instr"}, issue_req_instr, instr);
      if (i == is_st) issue_ready = 1;
    end
    tick();
    issue_ready = 0; issue_resp_accept = 0; issue_resp_writeback = 0;
    issue_resp_register_read = 0;
    if (acc && mask != 2'b00) begin
      chk({tag, ".reg_valid"}, register_valid, 1);
      chk({tag, ".reg_rs_valid"}, register_rs_valid, mask);
      chk({tag, ".reg_rs0"}, register_rs[0], mask[0] ? rs1 : 32'h0);
      chk({tag, ".reg_rs1"}, register_rs[1], mask[1] ? rs2 : 32'h0);
      register_ready = (rg_st == 0);
      for (int i = 1; i <= rg_st; i++) begin
        tick();
        chk({tag, ".reg_hold_rs0"}, register_rs[0], mask[0] ? rs1 : 32'h0);
        chk({tag, ".reg_hold_rs1"}, register_rs[1], mask[1] ? rs2 : 32'h0);
        if (i == rg_st) register_ready = 1;
      end
      tick();
      register_ready = 0;
    end
    if (acc) begin
      chk({tag, ".result_ready"}, result_ready, wb);
      if (wb) begin
        for (int i = 0; i < res_dly; i++) begin
          tick();
          chk({tag, ".wait_no_rsp"}, rsp_valid, 0);
        end
        result_valid = 1; result_data = res;
      end
      tick();
      result_valid = 0; result_data = 0;
    end
    lat = cyc - c0;
    chk({tag, ".rsp_valid"}, rsp_valid, 1);
    chk({tag, ".rsp_status"}, rsp_status, exp_st);
    chk({tag, ".rsp_data"}, rsp_data, exp_dat);
    rsp_ready = (rsp_st == 0);
    for (int i = 1; i <= rsp_st; i++) begin
      tick();
      chk({tag, ".rsp_hold_status"}, rsp_status, exp_st);
      chk({tag, ".rsp_hold_data"}, rsp_data, exp_dat);
      if (i == rsp_st) rsp_ready = 1;
    end
    tick();
    rsp_ready = 0;
    chk({tag, ".done_rsp_valid"}, rsp_valid, 0);
    chk({tag, ".done_req_ready"}, req_ready, 1);
    chk({tag, ".completions"}, n_cmp - n0, 1);
    if (!acc) chk({tag, ".no_reg_valid"}, saw_regv, 0);
  endtask

  // Brings a fresh accepted, no-operand, writeback transaction to its first WAIT cycle.
  task automatic to_wait;
    req_valid = 1; req_instr = 32'h0000207B; req_rs1 = 1; req_rs2 = 2;
    issue_ready = 1; issue_resp_accept = 1; issue_resp_writeback = 1;
    issue_resp_register_read = 2'b00;
    tick();
    req_valid = 0;
    tick();
    clear_inputs();
  endtask

  initial begin
    int lat, n0;
    logic seen;

    rst = 1;
    clear_inputs();
    tick();
    chk("reset.req_ready", req_ready, 1);
    chk("reset.issue_valid", issue_valid, 0);
    chk("reset.issue_instr", issue_req_instr, 0);
    chk("reset.register_valid", register_valid, 0);
    chk("reset.rs_valid", register_rs_valid, 0);
    chk("reset.result_ready", result_ready, 0);
    chk("reset.rsp_valid", rsp_valid, 0);
    chk("reset.rsp_status", rsp_status, 0);
    chk("reset.rsp_data", rsp_data, 0);
    tick();
    rst = 0;

    run_txn("add", 32'h0000007B, 32'h00010002, 32'h00030004, 1, 1, 2'b11, 32'h00040006,
            0, 0, 0, 0, 2'd0, 32'h00040006, lat);
    chk("add.latency", lat, 4);

    run_txn("conj", 32'h0000107B, 32'hAAAA0001, 32'h5555FFFF, 1, 1, 2'b01, 32'h12345678,
            0, 0, 0, 0, 2'd0, 32'h12345678, lat);

    run_txn("reject", 32'h0000307B, 32'h11111111, 32'h22222222, 0, 1, 2'b11, 32'h0,
            0, 0, 0, 0, 2'd1, 32'h0, lat);
    chk("reject.latency", lat, 2);

    run_txn("nowb", 32'h0000407B, 32'h33333333, 32'h44444444, 1, 0, 2'b10, 32'hCAFEF00D,
            0, 0, 0, 0, 2'd0, 32'h0, lat);

    run_txn("bp", 32'h0000507B, 32'h0BAD0001, 32'h0BAD0002, 1, 1, 2'b11, 32'h600DD00D,
            3, 2, 1, 2, 2'd0, 32'h600DD00D, lat);

    do_reset();
    req_valid = 1; req_instr = 32'h0000607B; req_rs1 = 32'h77; req_rs2 = 32'h88;
    issue_ready = 1; issue_resp_accept = 1; issue_resp_writeback = 1;
    issue_resp_register_read = 2'b11;
    tick();
    req_valid = 0;
    tick();
    clear_inputs();
    chk("rst_regs.in_regs", register_valid, 1);
    n0 = n_cmp;
    rst = 1;
    tick();
    rst = 0;
    chk("rst_regs.req_ready", req_ready, 1);
    chk("rst_regs.register_valid", register_valid, 0);
    chk("rst_regs.rsp_valid", rsp_valid, 0);
    tick();
    chk("rst_regs.still_no_rsp", rsp_valid, 0);
    chk("rst_regs.no_completion", n_cmp - n0, 0);
    run_txn("after_rst", 32'h0000707B, 32'h00000005, 32'h00000007, 1, 1, 2'b11, 32'h0000000C,
            0, 0, 0, 0, 2'd0, 32'h0000000C, lat);

    do_reset();
    to_wait();
    chk("wait.result_ready", result_ready, 1);
    seen = 0;
`ifdef CVXIF_ISSUER_TIMEOUT_EN
    for (int k = 1; k <= 7; k++) begin
      tick();
      seen = seen | rsp_valid;
    end
    chk("tmo.early_rsp", seen, 0);
    tick();
    chk("tmo.rsp_valid", rsp_valid, 1);
    chk("tmo.status", rsp_status, 2);
    chk("tmo.data", rsp_data, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    to_wait();
    seen = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      seen = seen | rsp_valid;
    end
    chk("tmo_race.early_rsp", seen, 0);
    result_valid = 1; result_data = 32'h0000ABCD;
    tick();
    result_valid = 0; result_data = 0;
    chk("tmo_race.rsp_valid", rsp_valid, 1);
    chk("tmo_race.status", rsp_status, 0);
    chk("tmo_race.data", rsp_data, 32'h0000ABCD);
`else
    for (int k = 1; k <= 20; k++) begin
      tick();
      seen = seen | rsp_valid;
    end
    chk("nowait_tmo.no_rsp", seen, 0);
    chk("nowait_tmo.result_ready", result_ready, 1);
    result_valid = 1; result_data = 32'h0000ABCD;
    tick();
    result_valid = 0; result_data = 0;
    chk("nowait_tmo.rsp_valid", rsp_valid, 1);
    chk("nowait_tmo.status", rsp_status, 0);
    chk("nowait_tmo.data", rsp_data, 32'h0000ABCD);
`endif
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("final.req_ready", req_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cvxif_issuer.md
CVXIF_ISSUER -- requirements
Module: cvxif_issuer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 256, result-wait limit in cycles (only with CVXIF_ISSUER_TIMEOUT_EN).
REQ-002 clk  in  1  clock; all logic on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  1  core offers an instruction.
REQ-005 req_ready  out  1  block can take a core request.
REQ-006 req_instr  in  32  instruction word.
REQ-007 req_rs1, req_rs2  in  32 each  source operand values.
REQ-008 issue_valid  out  1  issue request to coprocessor.
REQ-009 issue_ready  in  1  coprocessor takes the issue.
REQ-010 issue_req_instr  out  32  issued instruction.
REQ-011 issue_resp_accept, issue_resp_writeback  in  1 each  issue response; valid in the issue handshake cycle.
REQ-012 issue_resp_register_read  in  2  requested operand mask: bit0 = rs1, bit1 = rs2.
REQ-013 register_valid  out  1  operands valid.
REQ-014 register_ready  in  1  coprocessor takes the operands.
REQ-015 register_rs  out  2x32 unpacked [0:1]  operands; index 0 = rs1, index 1 = rs2.
REQ-016 register_rs_valid  out  2  per-operand valid mask.
REQ-017 result_valid  in  1; result_ready  out  1; result_data  in  32  result channel.
REQ-018 rsp_valid  out  1; rsp_ready  in  1  completion to core.
REQ-019 rsp_status  out  2  completion status: 0 OK, 1 REJECT, 2 TIMEOUT.
REQ-020 rsp_data  out  32  result value; 0 unless status is OK with writeback.

Function
REQ-021 The block shall run an FSM with states IDLE, ISSUE, REGS, WAIT, RESP and hold one transaction at a time.
REQ-022 IDLE
- req_ready=1.
- On req_valid: capture instr/rs1/rs2, go to ISSUE next cycle.
REQ-023 ISSUE
- issue_valid=1, issue_req_instr held stable until issue_ready.
- On issue_ready with accept=0: go to RESP, status REJECT.
- On issue_ready with accept=1: capture mask and writeback flag.
- Then: mask==00 goes to WAIT; otherwise goes to REGS.
REQ-024 REGS
- register_valid=1, register_rs_valid=captured mask, unrequested lanes driven 0.
- Held until register_ready, then go to WAIT.
REQ-025 WAIT
- result_ready=1 only while writeback=1.
- On result_valid: capture result_data, go to RESP with status OK.
- If writeback=0: go to RESP next cycle, status OK, data 0.
REQ-026 RESP
- rsp_valid=1, status/data held stable until rsp_ready, then go to IDLE.
- req_ready stays 0 until IDLE is re-entered.
REQ-027 Minimum latency, req_valid to rsp_valid with every ready high and result returned immediately: 4 cycles.
REQ-028 issue_valid, register_valid, result_ready and rsp_valid shall each be 1 only in their own state.

Reset
REQ-029 On rst the block shall enter IDLE and set these outputs: req_ready=1; all other outputs 0.
REQ-030 On rst it shall also clear captured data, mask, flag and timeout counter.
REQ-031 rst asserted in any state shall abort the transaction without a rsp_valid pulse.

Configuration
REQ-032 With CVXIF_ISSUER_TIMEOUT_EN defined, a counter shall clear on WAIT entry and increment each WAIT cycle without result_valid.
REQ-033 When that counter reaches TIMEOUT_CYCLES-1, the block shall go to RESP with status TIMEOUT and data 0.
REQ-034 If result_valid arrives in the same cycle as the timeout, the result shall win (status OK).
REQ-035 Without CVXIF_ISSUER_TIMEOUT_EN, no counter is built, WAIT waits indefinitely and status TIMEOUT never occurs.

Structure
REQ-036 A shared package cvxif_pkg shall hold:
- the state_t enum;
- the status_t enum (OK/REJECT/TIMEOUT);
- the constant CUSTOM3_OPCODE = 7'b1111011.
REQ-037 The timeout counter shall be the sub-module cvxif_timeout_ctr, instantiated only under CVXIF_ISSUER_TIMEOUT_EN.

Verification
REQ-038 Add accepted: instr 0x0000007B, rs1=0x00010002, rs2=0x00030004; coprocessor returns accept=1, mask=11, result 0x00040006 -> register_rs_valid=11, rsp_status=0, rsp_data=0x00040006.
REQ-039 Conjugate: instr 0x0000107B, mask=01 -> register_rs[1]=0 and register_rs_valid=01 during REGS; result returned unchanged on rsp_data.
REQ-040 Reject: accept=0 -> no register_valid ever asserted; rsp_status=1, rsp_data=0.
REQ-041 Backpressure: issue_ready low 3 cycles, register_ready low 2, rsp_ready low 2 -> issue_req_instr, register_rs and rsp_data stable throughout; exactly one completion.
REQ-042 Timeout (macro on, TIMEOUT_CYCLES=8): no result_valid -> rsp_status=2 exactly 8 cycles after WAIT entry; result_valid on cycle 8 instead -> status 0.
REQ-043 rst pulsed during REGS -> next cycle req_ready=1, register_valid=0, no rsp_valid; the following transaction completes normally.
